// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the pwm_capture block: FSM state encodings,
// the default counter width and the default saturation value.
package pwm_capture_pkg;

    localparam int unsigned PWM_CAP_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HIGH = 2'b01,
        LOW  = 2'b10
    } state_e;

    localparam logic [PWM_CAP_W-1:0] PWM_CAP_SAT = '1;

endpackage

// File: rtl/pwm_capture_rise_detect.sv
// Registers the previous input level and flags a 0->1 transition in the
// current cycle; usable by any edge-driven block.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= din_i;
        end
    end

    assign rise_o = din_i & ~prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and full period (rising edge to rising edge) of a
// synchronous pulse stream; flags a stuck input with a timeout strobe.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned W = PWM_CAP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] high_time,
    output logic [W-1:0] period,
    output logic         valid,
    output logic         timeout,
    output logic         level
);

    localparam logic [W-1:0] SAT = '1;
    localparam logic [W-1:0] ONE = W'(1);

    logic         rise;
    state_e       state_q;
    logic [W-1:0] hcnt_q;
    logic [W-1:0] pcnt_q;
    logic [W-1:0] high_time_q;
    logic [W-1:0] period_q;
    logic         valid_q;
    logic         timeout_q;
    logic         level_q;

    rise_detect u_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (din),
        .rise_o (rise)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            pcnt_q      <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            level_q     <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (!en) begin
                state_q <= IDLE;
                hcnt_q  <= '0;
                pcnt_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                            hcnt_q  <= ONE;
                            pcnt_q  <= ONE;
                        end
                    end
                    // HIGH always has prev=1, so a rise can only arrive in LOW;
                    // both states share the rise / saturate / count priority.
                    HIGH, LOW: begin
                        if (rise) begin
                            high_time_q <= hcnt_q;
                            period_q    <= pcnt_q;
                            valid_q     <= 1'b1;
                            state_q     <= HIGH;
                            hcnt_q      <= ONE;
                            pcnt_q      <= ONE;
                        end else if (pcnt_q == SAT) begin
                            state_q   <= IDLE;
                            timeout_q <= 1'b1;
                            level_q   <= din;
                            hcnt_q    <= '0;
                            pcnt_q    <= '0;
                        end else begin
                            pcnt_q <= pcnt_q + ONE;
                            if (din) begin
                                hcnt_q <= hcnt_q + ONE;
                            end else begin
                                state_q <= LOW;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        hcnt_q  <= '0;
                        pcnt_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign high_time = high_time_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a W=16 instance for period capture,
// reset and enable behaviour, and a W=4 instance for saturation/timeout.
module tb_pwm_capture;

    typedef struct {
        int h;
        int p;
        int c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        din;
    logic [15:0] high_time;
    logic [15:0] period;
    logic        valid;
    logic        timeout;
    logic        level;

    logic        en4;
    logic        d4;
    logic [3:0]  ht4;
    logic [3:0]  pd4;
    logic        v4;
    logic        to4;
    logic        lv4;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q[$];
    int   exp_h;
    int   exp_p;
    logic prev_m = 1'b0;
    logic armed  = 1'b0;
    int   pos    = 0;

    pwm_capture #(.W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .din       (din),
        .high_time (high_time),
        .period    (period),
        .valid     (valid),
        .timeout   (timeout),
        .level     (level)
    );

    pwm_capture #(.W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en4),
        .din       (d4),
        .high_time (ht4),
        .period    (pd4),
        .valid     (v4),
        .timeout   (to4),
        .level     (lv4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected captures come from the driven stream: every rise while enabled
    // and out of reset, except the one that (re)starts measurement.
    task automatic drive_bit(input logic b);
        logic r;
        r   = b & ~prev_m;
        din = b;
        if (!en || !rst_n) begin
            armed = 1'b0;
        end else if (r) begin
            if (armed) q.push_back('{exp_h, exp_p, cyc + 1});
            else armed = 1'b1;
        end
        prev_m = rst_n ? b : 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pat(input logic [15:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            drive_bit(pat[15 - (pos % 16)]);
            pos++;
        end
    endtask

    task automatic drain(input string tag);
        en = 1'b0;
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        check(tag, q.size(), 0);
        q.delete();
    endtask

    task automatic drive4(input logic b);
        d4 = b;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("high_time", high_time, e.h);
                check("period", period, e.p);
                check("valid_cycle", cyc, e.c);
            end
        end
        if (timeout === 1'b1) check("main_timeout", 1, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pats [6];
        int          hs   [6];
        int          ps   [6];
        int          n;
        int          vcnt;

        pats = '{16'b1010101010101010, 16'b1100110011001100, 16'b1111000011110000,
                 16'b1000000010000000, 16'b1110000000000000, 16'b1111111111100000};
        hs   = '{1, 2, 4, 1, 3, 11};
        ps   = '{2, 4, 8, 8, 16, 16};

        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        en4   = 1'b0;
        d4    = 1'b0;
        #3;
        check("rst_high_time", high_time, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        check("rst_level", level, 0);
        check("rst4_valid", v4, 0);
        check("rst4_timeout", to4, 0);
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 6; k++) begin
            exp_h = hs[k];
            exp_p = ps[k];
            pos   = 0;
            en    = 1'b1;
            drive_pat(pats[k], 48);
            drain("pattern_drain");
        end

        // asynchronous reset asserted mid-HIGH of a 4/8 stream
        exp_h = 4;
        exp_p = 8;
        pos   = 0;
        en    = 1'b1;
        drive_pat(16'b1111000011110000, 10);
        check("pre_reset_period", period, 8);
        #2;
        rst_n = 1'b0;
        armed = 1'b0;
        prev_m = 1'b0;
        q.delete();
        #1;
        check("arst_high_time", high_time, 0);
        check("arst_period", period, 0);
        check("arst_valid", valid, 0);
        check("arst_level", level, 0);
        drive_pat(16'b1111000011110000, 4);
        rst_n = 1'b1;
        drive_pat(16'b1111000011110000, 32);
        drain("reset_drain");

        // enable dropped for three cycles in a 2/4 stream
        exp_h = 2;
        exp_p = 4;
        pos   = 0;
        en    = 1'b1;
        drive_pat(16'b1100110011001100, 16);
        en = 1'b0;
        drive_pat(16'b1100110011001100, 3);
        en = 1'b1;
        drive_pat(16'b1100110011001100, 13);
        drain("enable_drain");

        // W=4: a rise exactly at pcnt=15 wins over saturation
        en4 = 1'b1;
        drive4(1'b0);
        drive4(1'b1);
        drive4(1'b1);
        drive4(1'b1);
        for (int i = 0; i < 12; i++) drive4(1'b0);
        drive4(1'b1);
        check("w4_edge_valid", v4, 1);
        check("w4_edge_timeout", to4, 0);
        check("w4_edge_high", ht4, 3);
        check("w4_edge_period", pd4, 15);

        // stuck high: timeout 15 edges after the rise
        n = 0;
        vcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            drive4(1'b1);
            if (v4) vcnt++;
            if (to4) begin
                n = i;
                break;
            end
        end
        check("w4_stuck1_delay", n, 15);
        check("w4_stuck1_level", lv4, 1);
        check("w4_stuck1_valids", vcnt, 0);
        check("w4_hold_high", ht4, 3);
        check("w4_hold_period", pd4, 15);
        drive4(1'b1);
        check("w4_timeout_oneshot", to4, 0);

        // stuck low
        drive4(1'b0);
        drive4(1'b1);
        n = 0;
        vcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            drive4(1'b0);
            if (v4) vcnt++;
            if (to4) begin
                n = i;
                break;
            end
        end
        check("w4_stuck0_delay", n, 15);
        check("w4_stuck0_level", lv4, 0);
        check("w4_stuck0_valids", vcnt, 0);
        en4 = 1'b0;
        drive4(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
